// File: rtl/icache_tag_pkg.sv
// Shared types for the instruction-cache tag controller: FSM states and the stored tag-entry layout.
package icache_tag_pkg;

    localparam int unsigned TAG_W         = 6;
    localparam int unsigned TAG_VALID_BIT = TAG_W;

    typedef enum logic [1:0] {
        INIT_SWEEP  = 2'd0,
        ACTIVE      = 2'd1,
        FLUSH_DRAIN = 2'd2,
        FLUSH_SWEEP = 2'd3
    } tag_state_e;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } tag_entry_t;

endpackage

// File: rtl/icache_tag_way_cmp.sv
// Per-way tag comparator: an entry hits when it is valid and its tag equals the looked-up tag.
module icache_tag_way_cmp
    import icache_tag_pkg::*;
#(
    parameter int unsigned TAG_WIDTH = TAG_W
) (
    input  logic [TAG_WIDTH:0]   entry_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    output logic                 hit_o
);

    assign hit_o = entry_i[TAG_WIDTH] & (entry_i[TAG_WIDTH-1:0] == tag_i);

endmodule

// File: rtl/icache_tag_lookup_ctrl.sv
// Tag-array controller: invalidation sweeps, refill writes and lookups with a one-hot hit vector.
// Optional macro ICACHE_TAG_LOOKUP_OUT_REG_EN adds an output register stage on the lookup result.
module icache_tag_lookup_ctrl
    import icache_tag_pkg::*;
#(
    parameter int unsigned NB_WAYS      = 4,
    parameter int unsigned SET_ID_WIDTH = 6,
    parameter int unsigned TAG_WIDTH    = 6
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             lookup_req_i,
    input  logic [SET_ID_WIDTH-1:0]          lookup_set_i,
    input  logic [TAG_WIDTH-1:0]             lookup_tag_i,
    output logic                             lookup_gnt_o,
    output logic                             lookup_rvalid_o,
    output logic                             lookup_hit_o,
    output logic [NB_WAYS-1:0]               lookup_hit_way_o,
    output logic                             lookup_multihit_o,
    input  logic                             refill_req_i,
    input  logic [SET_ID_WIDTH-1:0]          refill_set_i,
    input  logic [NB_WAYS-1:0]               refill_way_i,
    input  logic [TAG_WIDTH-1:0]             refill_tag_i,
    output logic                             refill_gnt_o,
    input  logic                             flush_req_i,
    output logic                             flush_ack_o,
    output logic                             init_done_o,
    output logic [NB_WAYS-1:0]               tag_req_o,
    output logic                             tag_write_o,
    output logic [SET_ID_WIDTH-1:0]          tag_addr_o,
    output logic [TAG_WIDTH:0]               tag_wdata_o,
    input  logic [NB_WAYS*(TAG_WIDTH+1)-1:0] tag_rdata_i
);

    localparam logic [SET_ID_WIDTH-1:0] LAST_IDX = '1;
    localparam logic [NB_WAYS-1:0]      WAY_ONE  = NB_WAYS'(1);

    tag_state_e              state_q, state_d;
    logic [SET_ID_WIDTH-1:0] cnt_q, cnt_d;
    logic                    init_done_q, init_done_d;
    logic                    flush_ack_q, flush_ack_d;
    logic                    pend_q, pend_d;
    logic [TAG_WIDTH-1:0]    tag_q, tag_d;
    logic                    out_busy;
    logic                    flush_take;
    logic [NB_WAYS-1:0]      hit_way;
    logic [NB_WAYS-1:0]      res_way;
    logic                    res_hit;
    logic                    res_multi;

    // The ack cycle itself must not restart a flush while the requester is still dropping its level.
    assign flush_take = flush_req_i & ~flush_ack_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        init_done_d  = init_done_q;
        flush_ack_d  = 1'b0;
        pend_d       = 1'b0;
        tag_d        = tag_q;
        tag_req_o    = '0;
        tag_write_o  = 1'b0;
        tag_addr_o   = '0;
        tag_wdata_o  = '0;
        lookup_gnt_o = 1'b0;
        refill_gnt_o = 1'b0;
        case (state_q)
            INIT_SWEEP, FLUSH_SWEEP: begin
                tag_req_o   = '1;
                tag_write_o = 1'b1;
                tag_addr_o  = cnt_q;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = ACTIVE;
                    if (state_q == INIT_SWEEP) begin
                        init_done_d = 1'b1;
                    end else begin
                        flush_ack_d = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (flush_take) begin
                    state_d = FLUSH_DRAIN;
                end else if (refill_req_i) begin
                    tag_req_o    = refill_way_i;
                    tag_write_o  = 1'b1;
                    tag_addr_o   = refill_set_i;
                    tag_wdata_o  = {1'b1, refill_tag_i};
                    refill_gnt_o = 1'b1;
                end else if (lookup_req_i) begin
                    tag_req_o    = '1;
                    tag_addr_o   = lookup_set_i;
                    lookup_gnt_o = 1'b1;
                    pend_d       = 1'b1;
                    tag_d        = lookup_tag_i;
                end
            end
            FLUSH_DRAIN: begin
                if (!pend_q && !out_busy) begin
                    state_d = FLUSH_SWEEP;
                    cnt_d   = '0;
                end
            end
            default: state_d = INIT_SWEEP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT_SWEEP;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            flush_ack_q <= 1'b0;
            pend_q      <= 1'b0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            flush_ack_q <= flush_ack_d;
            pend_q      <= pend_d;
            tag_q       <= tag_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NB_WAYS; gi++) begin : g_way
            icache_tag_way_cmp #(
                .TAG_WIDTH (TAG_WIDTH)
            ) u_cmp (
                .entry_i (tag_rdata_i[gi*(TAG_WIDTH+1) +: (TAG_WIDTH+1)]),
                .tag_i   (tag_q),
                .hit_o   (hit_way[gi])
            );
        end
    endgenerate

    // Read data is only meaningful in the cycle after a lookup grant.
    assign res_way   = pend_q ? hit_way : '0;
    assign res_hit   = |res_way;
    assign res_multi = |(res_way & (res_way - WAY_ONE));

`ifdef ICACHE_TAG_LOOKUP_OUT_REG_EN
    logic               rvalid_q;
    logic               hit_q;
    logic [NB_WAYS-1:0] way_q;
    logic               multi_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            hit_q    <= 1'b0;
            way_q    <= '0;
            multi_q  <= 1'b0;
        end else begin
            rvalid_q <= pend_q;
            hit_q    <= res_hit;
            way_q    <= res_way;
            multi_q  <= res_multi;
        end
    end

    assign out_busy          = rvalid_q;
    assign lookup_rvalid_o   = rvalid_q;
    assign lookup_hit_o      = hit_q;
    assign lookup_hit_way_o  = way_q;
    assign lookup_multihit_o = multi_q;
`else
    assign out_busy          = 1'b0;
    assign lookup_rvalid_o   = pend_q;
    assign lookup_hit_o      = res_hit;
    assign lookup_hit_way_o  = res_way;
    assign lookup_multihit_o = res_multi;
`endif

    assign flush_ack_o = flush_ack_q;
    assign init_done_o = init_done_q;

endmodule

// File: tb/tb_icache_tag_lookup_ctrl.sv
// Randomized and directed bench for icache_tag_lookup_ctrl against a cache-contents reference model.
module tb_icache_tag_lookup_ctrl;

    localparam int NW = 4;
    localparam int SW = 6;
    localparam int TW = 6;
    localparam int NSETS = 1 << SW;
`ifdef ICACHE_TAG_LOOKUP_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic            clk;
    logic            rst_n;
    logic            lreq;
    logic [SW-1:0]   lset;
    logic [TW-1:0]   ltag;
    logic            lgnt, rvalid, hit, multi;
    logic [NW-1:0]   hway;
    logic            rreq;
    logic [SW-1:0]   rset;
    logic [NW-1:0]   rway;
    logic [TW-1:0]   rtag;
    logic            rgnt;
    logic            flush_req, flush_ack, init_done;
    logic [NW-1:0]   tag_req;
    logic            tag_write;
    logic [SW-1:0]   tag_addr;
    logic [TW:0]     tag_wdata;
    logic [NW*(TW+1)-1:0] tag_rdata;

    icache_tag_lookup_ctrl #(.NB_WAYS(NW), .SET_ID_WIDTH(SW), .TAG_WIDTH(TW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .lookup_req_i      (lreq),
        .lookup_set_i      (lset),
        .lookup_tag_i      (ltag),
        .lookup_gnt_o      (lgnt),
        .lookup_rvalid_o   (rvalid),
        .lookup_hit_o      (hit),
        .lookup_hit_way_o  (hway),
        .lookup_multihit_o (multi),
        .refill_req_i      (rreq),
        .refill_set_i      (rset),
        .refill_way_i      (rway),
        .refill_tag_i      (rtag),
        .refill_gnt_o      (rgnt),
        .flush_req_i       (flush_req),
        .flush_ack_o       (flush_ack),
        .init_done_o       (init_done),
        .tag_req_o         (tag_req),
        .tag_write_o       (tag_write),
        .tag_addr_o        (tag_addr),
        .tag_wdata_o       (tag_wdata),
        .tag_rdata_i       (tag_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port tag memories, one per way, with one-cycle read latency.
    logic [TW:0] mem [NW][NSETS];
    logic [TW:0] rd  [NW];
    always @(posedge clk) begin
        for (int w = 0; w < NW; w++) begin
            if (tag_req[w]) begin
                if (tag_write) mem[w][tag_addr] <= tag_wdata;
                else           rd[w] <= mem[w][tag_addr];
            end
        end
    end
    generate
        for (genvar gi = 0; gi < NW; gi++) begin : g_rd
            assign tag_rdata[gi*(TW+1) +: (TW+1)] = rd[gi];
        end
    endgenerate

    // Reference model: what the cache holds, per way and set.
    bit            ref_v [NW][NSETS];
    logic [TW-1:0] ref_t [NW][NSETS];

    typedef struct {
        int            due;
        logic [NW-1:0] ways;
    } exp_t;
    exp_t q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_ack   = 0;
    int sweep_writes;
    int first_addr;
    bit g_r, g_l, s_init, s_ack;
    logic [NW-1:0] last_way;
    logic          last_hit, last_multi;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [NW-1:0] expect_ways(input logic [SW-1:0] s, input logic [TW-1:0] t);
        logic [NW-1:0] r;
        r = '0;
        for (int w = 0; w < NW; w++) r[w] = ref_v[w][s] && (ref_t[w][s] == t);
        return r;
    endfunction

    task automatic clear_model();
        for (int w = 0; w < NW; w++)
            for (int s = 0; s < NSETS; s++) ref_v[w][s] = 1'b0;
    endtask

    task automatic do_cycle(input bit flushing);
        exp_t e;
        @(negedge clk);
        cyc++;
        g_r    = rgnt;
        g_l    = lgnt;
        s_init = init_done;
        s_ack  = flush_ack;
        if (flush_ack) n_ack++;
        if (flushing && tag_write && tag_req == '1) begin
            if (sweep_writes == 0) first_addr = int'(tag_addr);
            sweep_writes++;
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            check("rvalid", rvalid, 1);
            check("hit", hit, |e.ways);
            check("hit_way", hway, e.ways);
            check("multihit", multi, ($countones(e.ways) > 1));
            last_way   = hway;
            last_hit   = hit;
            last_multi = multi;
        end else begin
            check("rvalid_idle", rvalid, 0);
        end
        if (flushing && !flush_ack) begin
            check("flush_no_rgnt", rgnt, 0);
            check("flush_no_lgnt", lgnt, 0);
        end else if (!flushing) begin
            check("refill_gnt", rgnt, rreq);
            check("lookup_gnt", lgnt, lreq & ~rreq);
        end
        if (rgnt) begin
            for (int w = 0; w < NW; w++) begin
                if (rway[w]) begin
                    ref_v[w][rset] = 1'b1;
                    ref_t[w][rset] = rtag;
                end
            end
        end
        if (lgnt) q.push_back('{cyc + LAT, expect_ways(lset, ltag)});
        @(posedge clk);
        #1;
        if (g_r) rreq = 1'b0;
        if (g_l) lreq = 1'b0;
    endtask

    // Expects rst_n already low; checks reset outputs, releases reset and checks the init sweep.
    task automatic reset_and_sweep();
        flush_req = 1'b0;
        lreq = 1'b1; lset = 6'd7; ltag = 6'd1;
        rreq = 1'b1; rset = 6'd7; rway = 4'b0001; rtag = 6'd1;
        q.delete();
        clear_model();
        #2;
        check("rst_lgnt", lgnt, 0);
        check("rst_rgnt", rgnt, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_hit", hit, 0);
        check("rst_hit_way", hway, 0);
        check("rst_multihit", multi, 0);
        check("rst_flush_ack", flush_ack, 0);
        check("rst_init_done", init_done, 0);
        check("rst_tag_req", tag_req, 4'hF);
        check("rst_tag_write", tag_write, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NSETS; i++) begin
            @(negedge clk);
            cyc++;
            check("sweep_write", tag_write, 1);
            check("sweep_addr", tag_addr, i);
            check("sweep_wdata", tag_wdata, 0);
            check("sweep_req", tag_req, 4'hF);
            check("sweep_lgnt", lgnt, 0);
            check("sweep_rgnt", rgnt, 0);
            check("sweep_init_done", init_done, 0);
            check("sweep_flush_ack", flush_ack, 0);
        end
        lreq = 1'b0;
        rreq = 1'b0;
        do_cycle(0);
        check("init_done_rise", s_init, 1);
    endtask

    task automatic refill(input logic [SW-1:0] s, input logic [NW-1:0] w, input logic [TW-1:0] t);
        int k;
        rreq = 1'b1; rset = s; rway = w; rtag = t;
        k = 0;
        while (rreq && k < 20) begin do_cycle(0); k++; end
        if (rreq) begin check("refill_timeout", 0, 1); rreq = 1'b0; end
    endtask

    task automatic lookup(input logic [SW-1:0] s, input logic [TW-1:0] t);
        int k;
        lreq = 1'b1; lset = s; ltag = t;
        k = 0;
        while (lreq && k < 20) begin do_cycle(0); k++; end
        if (lreq) begin check("lookup_timeout", 0, 1); lreq = 1'b0; end
        for (int i = 0; i < LAT; i++) do_cycle(0);
    endtask

    task automatic random_ops(input int n);
        int k;
        for (int i = 0; i < n; i++) begin
            if (!rreq && $urandom_range(0, 2) == 0) begin
                rreq = 1'b1;
                rset = 6'($urandom_range(0, 7));
                rway = 4'(1 << $urandom_range(0, 3));
                rtag = 6'($urandom_range(0, 3));
            end
            if (!lreq && $urandom_range(0, 2) != 0) begin
                lreq = 1'b1;
                lset = 6'($urandom_range(0, 7));
                ltag = 6'($urandom_range(0, 3));
            end
            do_cycle(0);
        end
        k = 0;
        while ((rreq || lreq) && k < 20) begin do_cycle(0); k++; end
        for (int i = 0; i < 3; i++) do_cycle(0);
    endtask

    initial begin
        rst_n = 1'b0;
        flush_req = 1'b0;
        lreq = 1'b0; lset = '0; ltag = '0;
        rreq = 1'b0; rset = '0; rway = '0; rtag = '0;
        last_way = '0; last_hit = 1'b0; last_multi = 1'b0;
        repeat (2) @(posedge clk);
        reset_and_sweep();

        // Basic hit and miss
        refill(6'd5, 4'b0100, 6'h2A);
        lookup(6'd5, 6'h2A);
        check("d1_hit", last_hit, 1);
        check("d1_hit_way", last_way, 4'b0100);
        lookup(6'd5, 6'h2B);
        check("d1_miss_hit", last_hit, 0);
        check("d1_miss_way", last_way, 4'b0000);

        // Refill and lookup in the same cycle
        rreq = 1'b1; rset = 6'd9; rway = 4'b0001; rtag = 6'h15;
        lreq = 1'b1; lset = 6'd9; ltag = 6'h15;
        do_cycle(0);
        check("d2_rgnt", g_r, 1);
        check("d2_lgnt_blocked", g_l, 0);
        do_cycle(0);
        check("d2_lgnt_next", g_l, 1);
        for (int i = 0; i < LAT; i++) do_cycle(0);
        check("d2_hit_way", last_way, 4'b0001);

        // Multi-hit
        refill(6'd3, 4'b0001, 6'h11);
        refill(6'd3, 4'b0010, 6'h11);
        lookup(6'd3, 6'h11);
        check("d3_hit_way", last_way, 4'b0011);
        check("d3_multihit", last_multi, 1);

        random_ops(400);

        // Flush with a lookup in flight
        refill(6'd10, 4'b1000, 6'h20);
        refill(6'd11, 4'b0010, 6'h21);
        refill(6'd12, 4'b0001, 6'h22);
        lreq = 1'b1; lset = 6'd10; ltag = 6'h20;
        do_cycle(0);
        check("d4_inflight_gnt", g_l, 1);
        clear_model();
        flush_req = 1'b1;
        lreq = 1'b1; lset = 6'd11; ltag = 6'h21;
        sweep_writes = 0; first_addr = -1; n_ack = 0;
        begin
            int k;
            k = 0;
            s_ack = 1'b0;
            while (!s_ack && k < 300) begin do_cycle(1); k++; end
            if (!s_ack) check("flush_ack_timeout", 0, 1);
        end
        flush_req = 1'b0;
        for (int i = 0; i < LAT + 3; i++) do_cycle(0);
        check("d4_inflight_hit", q.size(), 0);
        check("flush_sweep_len", sweep_writes, NSETS);
        check("flush_first_addr", first_addr, 0);
        check("flush_ack_once", n_ack, 1);
        lookup(6'd10, 6'h20);
        check("d4_miss10", last_hit, 0);
        lookup(6'd11, 6'h21);
        check("d4_miss11", last_hit, 0);
        lookup(6'd12, 6'h22);
        check("d4_miss12", last_hit, 0);

        // Reset mid-flush at counter 20
        refill(6'd2, 4'b0100, 6'h05);
        flush_req = 1'b1;
        sweep_writes = 0; first_addr = -1; n_ack = 0;
        begin
            int k;
            k = 0;
            while (sweep_writes < 20 && k < 300) begin do_cycle(1); k++; end
            if (sweep_writes < 20) check("flush20_timeout", 0, 1);
        end
        @(negedge clk);
        check("flush_cnt20", tag_addr, 20);
        rst_n = 1'b0;
        #1;
        check("rst20_addr", tag_addr, 0);
        check("rst20_init_done", init_done, 0);
        n_ack = 0;
        reset_and_sweep();
        check("rst20_no_ack", n_ack, 0);
        lookup(6'd2, 6'h05);
        check("rst20_miss", last_hit, 0);

        random_ops(300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
